// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package data_mem_arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_RD_WAIT} arb_state_t;
  typedef enum logic {GNT_CPU, GNT_AUX} arb_gnt_t;

  localparam int ARB_CNT_W = 3;

  // Initial wait-counter value for a read of the given RAM latency
  // (counter reaches 0 exactly in the data-return cycle).
  function automatic logic [ARB_CNT_W-1:0] rd_cnt_init(input int lat);
    return ARB_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_picker2.sv
// Combinational 2-way round-robin picker: bit 0 = CPU, bit 1 = aux.
module rr_picker2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  arb_gnt_t   last,
  output logic [1:0] gnt
);

  // One-hot grant; on contention the requester not served last wins.
  always_comb begin
    gnt = req;
    if (req[0] && req[1]) begin
      gnt = (last == GNT_AUX) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data-RAM port between the processor load/store path
// and an auxiliary requester. One access at a time, reads wait a fixed
// RAM latency, and the processor is stalled until its own access is done.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ABUS   = 32,
  parameter int DBUS   = 32,
  parameter int RD_LAT = 2
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_re,
  input  logic            cpu_we,
  input  logic [ABUS-1:0] cpu_addr,
  input  logic [DBUS-1:0] cpu_wdata,
  output logic [DBUS-1:0] cpu_rdata,
  output logic            cpu_stall,
  input  logic            aux_valid,
  input  logic            aux_we,
  input  logic [ABUS-1:0] aux_addr,
  input  logic [DBUS-1:0] aux_wdata,
  output logic            aux_ready,
  output logic [DBUS-1:0] aux_rdata,
  output logic            aux_rvalid,
  output logic            mem_re,
  output logic            mem_we,
  output logic [ABUS-1:0] mem_addr,
  output logic [DBUS-1:0] mem_wdata,
  input  logic [DBUS-1:0] mem_rdata
);

  localparam logic [ARB_CNT_W-1:0] RD_CNT_INIT = rd_cnt_init(RD_LAT);

  arb_state_t            state, state_nxt;
  arb_gnt_t              last_grant;
  arb_gnt_t              rd_owner;
  logic [ARB_CNT_W-1:0]  cnt;

  logic                  cpu_req;
  logic [1:0]            req;
  logic [1:0]            gnt;

  logic                  issue_p0;
  logic                  issue_cpu_p0;
  logic                  issue_aux_p0;
  logic                  issue_we_p0;
  logic [ABUS-1:0]       addr_p0;
  logic [DBUS-1:0]       wdata_p0;
  logic                  rd_done;
  logic                  cpu_rd_done;
  logic                  aux_rd_done;
  logic                  cpu_done;

  logic [ABUS-1:0]       addr_hold;
  logic [DBUS-1:0]       wdata_hold;
  logic [DBUS-1:0]       cpu_rdata_p1;
  logic [DBUS-1:0]       aux_rdata_p1;
  logic                  vld_p1;

  // Write wins when the processor raises both strobes.
  assign cpu_req = cpu_re | cpu_we;
  assign req     = {aux_valid, cpu_req};

  rr_picker2 u_picker (
    .req  (req),
    .last (last_grant),
    .gnt  (gnt)
  );

  // Issue decision and next state; nothing is issued while reset is held.
  always_comb begin
    state_nxt    = state;
    issue_p0     = 1'b0;
    issue_cpu_p0 = 1'b0;
    issue_aux_p0 = 1'b0;
    issue_we_p0  = 1'b0;
    addr_p0      = addr_hold;
    wdata_p0     = wdata_hold;
    rd_done      = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (!rst && (req != 2'b00)) begin
          issue_p0     = 1'b1;
          issue_cpu_p0 = gnt[0];
          issue_aux_p0 = gnt[1];
          if (gnt[0]) begin
            issue_we_p0 = cpu_we;
            addr_p0     = cpu_addr;
            wdata_p0    = cpu_wdata;
          end else begin
            issue_we_p0 = aux_we;
            addr_p0     = aux_addr;
            wdata_p0    = aux_wdata;
          end
          if (!issue_we_p0) begin
            state_nxt = ARB_RD_WAIT;
          end
        end
      end
      ARB_RD_WAIT: begin
        if (cnt == '0) begin
          rd_done   = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // ---- stage p0: issue cycle, RAM strobes driven combinationally ----
  assign mem_re    = issue_p0 & ~issue_we_p0;
  assign mem_we    = issue_p0 &  issue_we_p0;
  assign mem_addr  = addr_p0;
  assign mem_wdata = wdata_p0;
  assign aux_ready = issue_aux_p0;

  assign cpu_rd_done = rd_done & (rd_owner == GNT_CPU);
  assign aux_rd_done = rd_done & (rd_owner == GNT_AUX);
  assign cpu_done    = (issue_cpu_p0 & issue_we_p0) | cpu_rd_done;
  assign cpu_stall   = cpu_req & ~cpu_done & ~rst;

  // CPU sees RAM data directly in its done cycle, the captured copy otherwise.
  assign cpu_rdata   = cpu_rd_done ? mem_rdata : cpu_rdata_p1;

  // FSM state, fairness pointer, read owner and latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= GNT_AUX;
      rd_owner   <= GNT_CPU;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (issue_p0) begin
        last_grant <= issue_cpu_p0 ? GNT_CPU : GNT_AUX;
        if (!issue_we_p0) begin
          rd_owner <= issue_cpu_p0 ? GNT_CPU : GNT_AUX;
          cnt      <= RD_CNT_INIT;
        end
      end else if (state == ARB_RD_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Hold the last issued address/data so the RAM bus is stable when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else if (issue_p0) begin
      addr_hold  <= addr_p0;
      wdata_hold <= wdata_p0;
    end
  end

  // ---- stage p1: read-data capture at the end of the done cycle ----
  // Capture returned read data for whichever requester owned the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_p1 <= '0;
      aux_rdata_p1 <= '0;
      vld_p1       <= 1'b0;
    end else begin
      vld_p1 <= aux_rd_done;
      if (cpu_rd_done) begin
        cpu_rdata_p1 <= mem_rdata;
      end
      if (aux_rd_done) begin
        aux_rdata_p1 <= mem_rdata;
      end
    end
  end

  assign aux_rdata  = aux_rdata_p1;
  assign aux_rvalid = vld_p1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed corner cases plus a randomized
// two-requester phase checked by a scoreboard against a reference memory.
module tb_data_mem_arbiter;

  localparam int ABUS   = 32;
  localparam int DBUS   = 32;
  localparam int RD_LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cpu_re, cpu_we;
  logic [ABUS-1:0] cpu_addr;
  logic [DBUS-1:0] cpu_wdata;
  logic [DBUS-1:0] cpu_rdata;
  logic            cpu_stall;
  logic            aux_valid, aux_we;
  logic [ABUS-1:0] aux_addr;
  logic [DBUS-1:0] aux_wdata;
  logic            aux_ready;
  logic [DBUS-1:0] aux_rdata;
  logic            aux_rvalid;
  logic            mem_re, mem_we;
  logic [ABUS-1:0] mem_addr;
  logic [DBUS-1:0] mem_wdata;
  logic [DBUS-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [DBUS-1:0] cpu_exp[$];
  logic [DBUS-1:0] aux_exp[$];
  logic [DBUS-1:0] cpu_ref [0:63];
  logic [DBUS-1:0] aux_ref [0:63];
  logic [DBUS-1:0] pop_val;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ABUS(ABUS), .DBUS(DBUS), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_valid(aux_valid), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [DBUS-1:0] init_val(input int i);
    if (i == 1) return 32'h3F;
    if (i == 4) return 32'hA5;
    return 32'h1000_0000 + i * 32'h0101;
  endfunction

  // RAM model: 128 words at addr[8:2], fixed read latency, garbage when idle.
  logic [DBUS-1:0] ram [0:127];
  logic            pv [RD_LAT];
  logic [ABUS-1:0] pa [RD_LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) ram[i] <= init_val(i);
      for (int i = 0; i < RD_LAT; i++) begin pv[i] <= 1'b0; pa[i] <= '0; end
    end else begin
      if (mem_we) ram[mem_addr[8:2]] <= mem_wdata;
      pv[0] <= mem_re;
      pa[0] <= mem_addr;
      for (int i = 1; i < RD_LAT; i++) begin pv[i] <= pv[i-1]; pa[i] <= pa[i-1]; end
    end
  end
  assign mem_rdata = pv[RD_LAT-1] ? ram[pa[RD_LAT-1][8:2]] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops expected read data when the DUT presents it, and checks
  // that no access is issued while a read is still in flight.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_re && !cpu_we && !cpu_stall) begin
        checks++;
        if (cpu_exp.size() == 0) begin
          failures++;
          $display("FAIL cpu_read_unexpected actual=%0h required=none", cpu_rdata);
        end else begin
          pop_val = cpu_exp.pop_front();
          if (cpu_rdata !== pop_val) begin
            failures++;
            $display("FAIL cpu_rdata actual=%0h required=%0h", cpu_rdata, pop_val);
          end
        end
      end
      if (aux_rvalid) begin
        checks++;
        if (aux_exp.size() == 0) begin
          failures++;
          $display("FAIL aux_rvalid_unexpected actual=%0h required=none", aux_rdata);
        end else begin
          pop_val = aux_exp.pop_front();
          if (aux_rdata !== pop_val) begin
            failures++;
            $display("FAIL aux_rdata actual=%0h required=%0h", aux_rdata, pop_val);
          end
        end
      end
      if (mem_re || mem_we) begin
        logic busy;
        busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) busy = busy | pv[i];
        checks++;
        if (busy || (mem_re && mem_we)) begin
          failures++;
          $display("FAIL issue_exclusive actual=re%0b_we%0b_busy%0b required=single_idle", mem_re, mem_we, busy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cpu(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (cpu_stall && n < 30) begin n++; @(negedge clk); end
    if (cpu_stall) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=stall1 required=stall0", tag);
    end
    tick();
  endtask

  task automatic wait_aux(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!aux_ready && n < 30) begin n++; @(negedge clk); end
    if (!aux_ready) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=ready0 required=ready1", tag);
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cpu_random(input int n_txn);
    for (int n = 0; n < n_txn; n++) begin
      int w;
      int kind;
      w    = $urandom_range(0, 63);
      kind = $urandom_range(0, 2);
      cpu_addr  = ABUS'(w * 4);
      cpu_wdata = $urandom;
      cpu_re    = (kind != 1);
      cpu_we    = (kind != 0);
      if (kind == 0) cpu_exp.push_back(cpu_ref[w]);
      else           cpu_ref[w] = cpu_wdata;
      wait_cpu("cpu_rand");
      cpu_re = 1'b0; cpu_we = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic aux_random(input int n_txn);
    for (int n = 0; n < n_txn; n++) begin
      int w;
      w         = $urandom_range(0, 63);
      aux_addr  = ABUS'((w + 64) * 4);
      aux_wdata = $urandom;
      aux_we    = $urandom_range(0, 1);
      aux_valid = 1'b1;
      if (!aux_we) aux_exp.push_back(aux_ref[w]);
      else         aux_ref[w] = aux_wdata;
      wait_aux("aux_rand");
      aux_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_valid = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_strobes", {mem_re, mem_we, cpu_stall, aux_ready, aux_rvalid}, 5'b0);
    check("rst_rdata", {cpu_rdata, aux_rdata}, 64'h0);
    check("rst_bus", {mem_addr, mem_wdata}, 64'h0);
    tick();
    rst = 1'b0;

    // CPU write alone
    cpu_we = 1; cpu_addr = 32'h8; cpu_wdata = 32'h9;
    @(negedge clk);
    check("wr_strobe", {mem_we, mem_re, cpu_stall}, 3'b100);
    check("wr_bus", {mem_addr, mem_wdata}, {32'h8, 32'h9});
    tick();
    cpu_we = 0;
    @(negedge clk);
    check("idle_hold", {mem_we, mem_addr}, {1'b0, 32'h8});
    tick();

    // CPU read alone: stall in T and T+1, data in T+2
    cpu_re = 1; cpu_addr = 32'h4;
    cpu_exp.push_back(32'h3F);
    @(negedge clk);
    check("rd_T", {cpu_stall, mem_re, mem_addr}, {2'b11, 32'h4});
    @(negedge clk);
    check("rd_T1", {cpu_stall, mem_re}, 2'b10);
    @(negedge clk);
    check("rd_T2", cpu_stall, 1'b0);
    tick();
    cpu_re = 0;
    @(negedge clk);
    check("rd_hold", cpu_rdata, 32'h3F);
    tick();

    // Tie after reset: CPU first, then aux on the repeated tie
    do_reset();
    cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
    aux_valid = 1; aux_we = 1; aux_addr = 32'h120; aux_wdata = 32'h66;
    @(negedge clk);
    check("tie_T", {aux_ready, mem_we, cpu_stall, mem_addr}, {3'b010, 32'h20});
    tick();
    cpu_addr = 32'h24; cpu_wdata = 32'h77;
    @(negedge clk);
    check("tie_T1", {aux_ready, cpu_stall, mem_addr, mem_wdata}, {2'b11, 32'h120, 32'h66});
    tick();
    aux_valid = 0;
    @(negedge clk);
    check("tie_T2", {aux_ready, cpu_stall, mem_addr}, {2'b00, 32'h24});
    tick();
    cpu_we = 0;

    // Aux read vs CPU read: serialized, aux first (CPU was granted last)
    aux_valid = 1; aux_we = 0; aux_addr = 32'h10;
    cpu_re = 1; cpu_addr = 32'h14;
    aux_exp.push_back(32'hA5);
    cpu_exp.push_back(init_val(5));
    @(negedge clk);
    check("rr_T", {aux_ready, mem_re, cpu_stall, mem_addr}, {3'b111, 32'h10});
    tick();
    aux_valid = 0;
    @(negedge clk);
    check("rr_T1", {mem_re, cpu_stall}, 2'b01);
    @(negedge clk);
    check("rr_T2", {mem_re, cpu_stall}, 2'b01);
    @(negedge clk);
    check("rr_T3", {aux_rvalid, mem_re, cpu_stall, mem_addr}, {3'b111, 32'h14});
    @(negedge clk);
    check("rr_T4", {aux_rvalid, cpu_stall}, 2'b01);
    @(negedge clk);
    check("rr_T5", cpu_stall, 1'b0);
    tick();
    cpu_re = 0;
    tick();

    // Reset in the middle of a CPU read
    cpu_re = 1; cpu_addr = 32'h18;
    @(negedge clk);
    check("rrst_T", cpu_stall, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check("rrst_async", {mem_re, mem_we, cpu_stall, aux_ready, aux_rvalid}, 5'b0);
    check("rrst_data", {cpu_rdata, mem_addr}, 64'h0);
    cpu_re = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rrst_after", {aux_rvalid, cpu_rdata}, 33'h0);
    end
    tick();

    // Both CPU strobes: write only, then read it back
    cpu_re = 1; cpu_we = 1; cpu_addr = 32'hC; cpu_wdata = 32'h12;
    @(negedge clk);
    check("both_T", {mem_we, mem_re, cpu_stall, mem_wdata}, {3'b100, 32'h12});
    tick();
    cpu_we = 0;
    cpu_exp.push_back(32'h12);
    wait_cpu("both_readback");
    cpu_re = 0;
    tick();

    // Randomized concurrent traffic on disjoint address regions
    do_reset();
    for (int i = 0; i < 64; i++) begin
      cpu_ref[i] = init_val(i);
      aux_ref[i] = init_val(i + 64);
    end
    fork
      cpu_random(150);
      aux_random(150);
    join
    repeat (10) tick();
    check("cpu_queue_empty", cpu_exp.size(), 0);
    check("aux_queue_empty", aux_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
